// File: rtl/floo_id_stall_tracker.sv
// Per-ID outstanding-transaction tracker. It stalls a request whose ID still
// has transactions in flight to a different destination, or already has the maximum number in flight.
module floo_id_stall_tracker #(
  parameter int unsigned NumIds       = 32'd4,
  parameter int unsigned MaxTxnsPerId = 32'd8,
  parameter int unsigned DstWidth     = 32'd8,
  localparam int unsigned IdWidth     = (NumIds > 32'd1) ? $clog2(NumIds) : 32'd1,
  localparam int unsigned CntWidth    = $clog2(MaxTxnsPerId + 32'd1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [IdWidth-1:0]  req_id_i,
  input  logic [DstWidth-1:0] req_dst_i,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  input  logic                rsp_valid_i,
  input  logic                rsp_ready_i,
  input  logic [IdWidth-1:0]  rsp_id_i,
  input  logic                rsp_last_i,
  output logic [NumIds-1:0]   busy_ids_o,
  output logic                idle_o,
  output logic                err_o
);

  typedef logic [CntWidth-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(MaxTxnsPerId);

  cnt_t                cnt_q [NumIds];
  cnt_t                cnt_d [NumIds];
  logic [DstWidth-1:0] dst_q [NumIds];
  logic [DstWidth-1:0] dst_d [NumIds];
  logic [NumIds-1:0]   busy_q, busy_d;
  logic                idle_q, idle_d;
  logic                err_q, err_d;

  logic [NumIds-1:0]   req_hit_s, rsp_hit_s;
  cnt_t                req_cnt_s, rsp_cnt_s;
  logic [DstWidth-1:0] req_dst_s;
  logic                req_in_range_s, rsp_in_range_s;
  logic                pass_s, req_fire_s, rsp_fire_s;

  // One-hot ID decode and selection of the addressed counter/destination.
  // An out-of-range ID hits no entry, so it never passes and always underflows.
  always_comb begin
    req_hit_s = '0;
    rsp_hit_s = '0;
    req_cnt_s = '0;
    rsp_cnt_s = '0;
    req_dst_s = '0;
    for (int unsigned i = 0; i < NumIds; i++) begin
      req_hit_s[i] = (32'(req_id_i) == i);
      rsp_hit_s[i] = (32'(rsp_id_i) == i);
      req_cnt_s    = req_cnt_s | (req_hit_s[i] ? cnt_q[i] : '0);
      rsp_cnt_s    = rsp_cnt_s | (rsp_hit_s[i] ? cnt_q[i] : '0);
      req_dst_s    = req_dst_s | (req_hit_s[i] ? dst_q[i] : '0);
    end
  end

  assign req_in_range_s = |req_hit_s;
  assign rsp_in_range_s = |rsp_hit_s;

  // The pass decision uses registered state only, so a response that empties an ID
  // cannot release a different-destination request in the same cycle.
  assign pass_s = req_in_range_s &
                  ((req_cnt_s == '0) | ((req_dst_s == req_dst_i) & (req_cnt_s < CntMax)));

  assign req_valid_o = req_valid_i & pass_s;
  assign req_ready_o = req_ready_i & pass_s;
  assign req_fire_s  = req_valid_i & req_ready_o;
  assign rsp_fire_s  = rsp_valid_i & rsp_ready_i & rsp_last_i;

  // Next-state for counters, destinations and the status flags.
  always_comb begin
    err_d  = rsp_fire_s & (~rsp_in_range_s | (rsp_cnt_s == '0));
    busy_d = '0;
    for (int unsigned i = 0; i < NumIds; i++) begin
      case ({req_fire_s & req_hit_s[i], rsp_fire_s & rsp_hit_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + cnt_t'(1'b1);
        2'b01:   cnt_d[i] = (cnt_q[i] != '0) ? (cnt_q[i] - cnt_t'(1'b1)) : cnt_q[i];
        default: cnt_d[i] = cnt_q[i];
      endcase
      dst_d[i]  = (req_fire_s & req_hit_s[i] & (cnt_q[i] == '0)) ? req_dst_i : dst_q[i];
      busy_d[i] = (cnt_d[i] != '0);
    end
    idle_d = ~|busy_d;
  end

  // State registers; status flags follow the counters they describe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        cnt_q[i] <= '0;
        dst_q[i] <= '0;
      end
      busy_q <= '0;
      idle_q <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        cnt_q[i] <= cnt_d[i];
        dst_q[i] <= dst_d[i];
      end
      busy_q <= busy_d;
      idle_q <= idle_d;
      err_q  <= err_d;
    end
  end

  assign busy_ids_o = busy_q;
  assign idle_o     = idle_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_floo_id_stall_tracker.sv
// Directed bench for floo_id_stall_tracker: each step pushes its expected outputs
// to a queue that a negedge monitor pops and compares.
module tb_floo_id_stall_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid_i = 1'b0, req_ready_i = 1'b0;
  logic       req_valid_o, req_ready_o;
  logic [1:0] req_id_i = 2'd0;
  logic [7:0] req_dst_i = 8'h00;
  logic       rsp_valid_i = 1'b0, rsp_ready_i = 1'b0, rsp_last_i = 1'b0;
  logic [1:0] rsp_id_i = 2'd0;
  logic [3:0] busy_ids_o;
  logic       idle_o, err_o;

  typedef struct packed {
    logic       vo;
    logic       ro;
    logic [3:0] busy;
    logic       idle;
    logic       err;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  floo_id_stall_tracker dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_id_i    (req_id_i),
    .req_dst_i   (req_dst_i),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_i    (rsp_id_i),
    .rsp_last_i  (rsp_last_i),
    .busy_ids_o  (busy_ids_o),
    .idle_o      (idle_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: the outputs seen mid-cycle must match the expectation queued for that cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      cmp(nm, "req_valid_o", {3'b000, req_valid_o}, {3'b000, e.vo});
      cmp(nm, "req_ready_o", {3'b000, req_ready_o}, {3'b000, e.ro});
      cmp(nm, "busy_ids_o",  busy_ids_o,            e.busy);
      cmp(nm, "idle_o",      {3'b000, idle_o},      {3'b000, e.idle});
      cmp(nm, "err_o",       {3'b000, err_o},       {3'b000, e.err});
    end
  end

  task automatic step(input string nm, input logic rst,
                      input logic rv, input logic rr, input logic [1:0] id, input logic [7:0] dst,
                      input logic sv, input logic [1:0] sid, input logic sl,
                      input logic evo, input logic ero, input logic [3:0] ebusy,
                      input logic eidle, input logic eerr);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = rst;
    req_valid_i = rv;
    req_ready_i = rr;
    req_id_i    = id;
    req_dst_i   = dst;
    rsp_valid_i = sv;
    rsp_ready_i = sv;
    rsp_id_i    = sid;
    rsp_last_i  = sl;
    e = '{vo: evo, ro: ero, busy: ebusy, idle: eidle, err: eerr};
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //    name            rst  rv    rr    id    dst    sv    sid   sl  | vo    ro    busy     idle  err
    step("rst_hold",      1'b0,1'b0,1'b0,2'd0,8'h00,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0000,1'b1,1'b0);
    step("post_rst",      1'b1,1'b1,1'b0,2'd0,8'h00,1'b0,2'd0,1'b0,   1'b1,1'b0,4'b0000,1'b1,1'b0);
    step("id1_a",         1'b1,1'b1,1'b1,2'd1,8'h05,1'b0,2'd0,1'b0,   1'b1,1'b1,4'b0000,1'b1,1'b0);
    step("id1_b",         1'b1,1'b1,1'b1,2'd1,8'h05,1'b0,2'd0,1'b0,   1'b1,1'b1,4'b0010,1'b0,1'b0);
    step("id1_c",         1'b1,1'b1,1'b1,2'd1,8'h05,1'b0,2'd0,1'b0,   1'b1,1'b1,4'b0010,1'b0,1'b0);
    step("cnt3",          1'b1,1'b0,1'b0,2'd0,8'h00,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0010,1'b0,1'b0);
    step("diff_dst",      1'b1,1'b1,1'b1,2'd1,8'h07,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0010,1'b0,1'b0);
    step("drain1",        1'b1,1'b1,1'b1,2'd1,8'h07,1'b1,2'd1,1'b1,   1'b0,1'b0,4'b0010,1'b0,1'b0);
    step("drain2",        1'b1,1'b1,1'b1,2'd1,8'h07,1'b1,2'd1,1'b1,   1'b0,1'b0,4'b0010,1'b0,1'b0);
    step("drain3",        1'b1,1'b1,1'b1,2'd1,8'h07,1'b1,2'd1,1'b1,   1'b0,1'b0,4'b0010,1'b0,1'b0);
    step("release",       1'b1,1'b1,1'b1,2'd1,8'h07,1'b0,2'd0,1'b0,   1'b1,1'b1,4'b0000,1'b1,1'b0);
    step("new_dst",       1'b1,1'b1,1'b1,2'd1,8'h07,1'b0,2'd0,1'b0,   1'b1,1'b1,4'b0010,1'b0,1'b0);
    step("old_dst",       1'b1,1'b1,1'b1,2'd1,8'h05,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0010,1'b0,1'b0);
    step("rsp_a",         1'b1,1'b0,1'b0,2'd0,8'h00,1'b1,2'd1,1'b1,   1'b0,1'b0,4'b0010,1'b0,1'b0);
    step("rsp_b",         1'b1,1'b0,1'b0,2'd0,8'h00,1'b1,2'd1,1'b1,   1'b0,1'b0,4'b0010,1'b0,1'b0);
    step("idle",          1'b1,1'b0,1'b0,2'd0,8'h00,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0000,1'b1,1'b0);
    for (int k = 0; k < 8; k++) begin
      step("fill",        1'b1,1'b1,1'b1,2'd0,8'h20,1'b0,2'd0,1'b0,   1'b1,1'b1,(k == 0) ? 4'b0000 : 4'b0001,
                                                                       (k == 0) ? 1'b1 : 1'b0, 1'b0);
    end
    step("full_stall",    1'b1,1'b1,1'b1,2'd0,8'h20,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0001,1'b0,1'b0);
    step("full_rsp",      1'b1,1'b1,1'b1,2'd0,8'h20,1'b1,2'd0,1'b1,   1'b0,1'b0,4'b0001,1'b0,1'b0);
    step("refill",        1'b1,1'b1,1'b1,2'd0,8'h20,1'b0,2'd0,1'b0,   1'b1,1'b1,4'b0001,1'b0,1'b0);
    step("full_again",    1'b1,1'b1,1'b1,2'd0,8'h20,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0001,1'b0,1'b0);
    step("indep_id2",     1'b1,1'b1,1'b1,2'd2,8'h33,1'b0,2'd0,1'b0,   1'b1,1'b1,4'b0001,1'b0,1'b0);
    step("same_cyc",      1'b1,1'b1,1'b1,2'd2,8'h33,1'b1,2'd2,1'b1,   1'b1,1'b1,4'b0101,1'b0,1'b0);
    step("hold_chk",      1'b1,1'b0,1'b0,2'd0,8'h00,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0101,1'b0,1'b0);
    step("rsp_id2",       1'b1,1'b0,1'b0,2'd0,8'h00,1'b1,2'd2,1'b1,   1'b0,1'b0,4'b0101,1'b0,1'b0);
    step("id2_done",      1'b1,1'b0,1'b0,2'd0,8'h00,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0001,1'b0,1'b0);
    step("rsp_underflow", 1'b1,1'b0,1'b0,2'd0,8'h00,1'b1,2'd3,1'b1,   1'b0,1'b0,4'b0001,1'b0,1'b0);
    step("err_pulse",     1'b1,1'b0,1'b0,2'd0,8'h00,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0001,1'b0,1'b1);
    step("nonlast",       1'b1,1'b0,1'b0,2'd0,8'h00,1'b1,2'd0,1'b0,   1'b0,1'b0,4'b0001,1'b0,1'b0);
    step("nonlast_chk",   1'b1,1'b1,1'b1,2'd0,8'h20,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0001,1'b0,1'b0);
    step("mid_a",         1'b1,1'b1,1'b1,2'd1,8'h44,1'b0,2'd0,1'b0,   1'b1,1'b1,4'b0001,1'b0,1'b0);
    step("mid_b",         1'b1,1'b1,1'b1,2'd1,8'h44,1'b0,2'd0,1'b0,   1'b1,1'b1,4'b0011,1'b0,1'b0);
    step("reset_mid",     1'b0,1'b0,1'b0,2'd0,8'h00,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0000,1'b1,1'b0);
    step("post_rst2",     1'b1,1'b1,1'b1,2'd1,8'h99,1'b0,2'd0,1'b0,   1'b1,1'b1,4'b0000,1'b1,1'b0);
    step("stale_rsp",     1'b1,1'b0,1'b0,2'd0,8'h00,1'b1,2'd0,1'b1,   1'b0,1'b0,4'b0010,1'b0,1'b0);
    step("stale_err",     1'b1,1'b0,1'b0,2'd0,8'h00,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0010,1'b0,1'b1);
    step("err_clear",     1'b1,1'b0,1'b0,2'd0,8'h00,1'b0,2'd0,1'b0,   1'b0,1'b0,4'b0010,1'b0,1'b0);

    repeat (3) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
